// File: rtl/morra_pkg.sv
// Shared types for the Morracinese game path: move encoding, collector states
// and the manche base count added to the manchemax code.
package morra_pkg;

  typedef enum logic [1:0] {
    MV_NONE    = 2'b00,
    MV_SASSO   = 2'b01,
    MV_CARTA   = 2'b10,
    MV_FORBICE = 2'b11
  } move_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_COLLECT,
    ST_ISSUE,
    ST_RESULT,
    ST_DONE
  } collector_state_t;

  // A game configured with code cfg_max plays cfg_max + MANCHE_BASE manches.
  localparam int unsigned MANCHE_BASE = 4;

  function automatic logic is_move(input logic [1:0] m);
    return m != MV_NONE;
  endfunction

endpackage

// File: rtl/move_collector_if.sv
// Player-side valid/ready handshake of the move collector, one channel per player.
// Players drive through the master modport; the collector uses the slave modport.
interface move_collector_if;
  logic       p1_valid;
  logic [1:0] p1_move;
  logic       p1_ready;
  logic       p2_valid;
  logic [1:0] p2_move;
  logic       p2_ready;

  modport master (output p1_valid, p1_move, p2_valid, p2_move,
                  input  p1_ready, p2_ready);
  modport slave  (input  p1_valid, p1_move, p2_valid, p2_move,
                  output p1_ready, p2_ready);
endinterface

// File: rtl/move_slot.sv
// One player's move slot: holds a single captured move, drops ready while full,
// and never captures the 00 code.
module move_slot
  import morra_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic       valid,
  input  logic [1:0] move,
  output logic       ready,
  output logic       capture,
  output logic       full,
  output logic [1:0] value
);

  assign ready   = enable && !full;
  assign capture = valid && ready && is_move(move) && !clear;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      full  <= 1'b0;
      value <= MV_NONE;
    end else if (capture) begin
      full  <= 1'b1;
      value <= move;
    end
  end

endmodule

// File: rtl/move_collector.sv
// Front-end of the Morracinese game: configures the game, pairs one move per
// player into a round, and stops once the game reports a result. MOVE_TIMEOUT_EN adds a forfeit timer.
module move_collector
  import morra_pkg::*;
#(
  parameter int CNT_W = 5
`ifdef MOVE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           cfg_max,
  move_collector_if.slave      mv,
  input  logic [1:0]           partita_in,
  output logic                 game_reset,
  output logic [1:0]           g1,
  output logic [1:0]           g2,
  output logic                 round_strobe,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     round_cnt,
  output logic                 timeout_flag
);

  collector_state_t state, state_nxt;
  logic [3:0] cfg_q;
  logic       collect, in_game, clear_slots, tmo_hit, both_next;
  logic       cap1, cap2, full1, full2;
  logic [1:0] slot1, slot2;

  assign collect     = (state == ST_COLLECT);
  assign in_game     = (state == ST_COLLECT) || (state == ST_ISSUE) || (state == ST_RESULT);
  // An abort must beat a same-cycle capture, so start clears the slots directly.
  assign clear_slots = (state == ST_ISSUE) || (start && in_game);

  move_slot u_slot1 (
    .clk(clk), .reset(reset), .enable(collect), .clear(clear_slots),
    .valid(mv.p1_valid), .move(mv.p1_move), .ready(mv.p1_ready),
    .capture(cap1), .full(full1), .value(slot1)
  );

  move_slot u_slot2 (
    .clk(clk), .reset(reset), .enable(collect), .clear(clear_slots),
    .valid(mv.p2_valid), .move(mv.p2_move), .ready(mv.p2_ready),
    .capture(cap2), .full(full2), .value(slot2)
  );

  assign both_next = (full1 || cap1) && (full2 || cap2);

`ifdef MOVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts the cycles the second player has had; any cycle outside the
  // one-slot-full COLLECT window (ISSUE, start, reset) returns it to zero.
  always_ff @(posedge clk) begin
    if (!reset || start || !(collect && (full1 ^ full2)))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit      = collect && (full1 ^ full2) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = (state == ST_ISSUE) && !(full1 && full2);
`else
  assign tmo_hit      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cfg_q     <= '0;
      round_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start)
        cfg_q <= cfg_max;
      if (state == ST_CFG)
        round_cnt <= '0;
      else if (state == ST_ISSUE && round_cnt != '1)
        round_cnt <= round_cnt + CNT_W'(1);
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_nxt    = state;
    game_reset   = 1'b0;
    g1           = MV_NONE;
    g2           = MV_NONE;
    round_strobe = 1'b0;
    unique case (state)
      ST_IDLE: begin
        game_reset = 1'b1;
        if (start) state_nxt = ST_CFG;
      end
      ST_CFG: begin
        game_reset = 1'b1;
        g1         = cfg_q[3:2];
        g2         = cfg_q[1:0];
        state_nxt  = start ? ST_CFG : ST_COLLECT;
      end
      ST_COLLECT: begin
        if (start)                     state_nxt = ST_CFG;
        else if (both_next || tmo_hit) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        g1           = slot1;
        g2           = slot2;
        round_strobe = 1'b1;
        state_nxt    = start ? ST_CFG : ST_RESULT;
      end
      ST_RESULT: begin
        if (start)                   state_nxt = ST_CFG;
        else if (partita_in != 2'b00) state_nxt = ST_DONE;
        else                         state_nxt = ST_COLLECT;
      end
      ST_DONE: begin
        if (start) state_nxt = ST_CFG;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE) && (state != ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_move_collector.sv
// Directed bench for move_collector: a scoreboard of expected rounds is filled as
// moves are offered and drained whenever round_strobe is seen.
module tb_move_collector;
  import morra_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] cfg_max;
  logic [1:0] partita_in;
  logic       game_reset, round_strobe, busy, done, timeout_flag;
  logic [1:0] g1, g2;
  logic [4:0] round_cnt;

  typedef struct packed {
    logic [1:0] g1;
    logic [1:0] g2;
    logic       tmo;
  } round_t;

  round_t exp_q[$];
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  move_collector_if mv_if ();

  move_collector #(
    .CNT_W(5)
`ifdef MOVE_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_max(cfg_max), .mv(mv_if),
    .partita_in(partita_in), .game_reset(game_reset), .g1(g1), .g2(g2),
    .round_strobe(round_strobe), .busy(busy), .done(done),
    .round_cnt(round_cnt), .timeout_flag(timeout_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v1, input logic [1:0] m1, input logic v2, input logic [1:0] m2);
    mv_if.p1_valid = v1;
    mv_if.p1_move  = m1;
    mv_if.p2_valid = v2;
    mv_if.p2_move  = m2;
  endtask

  // Both players offer in the same COLLECT cycle; returns in the next COLLECT.
  task automatic play_round(input logic [1:0] m1, input logic [1:0] m2);
    exp_q.push_back('{g1: m1, g2: m2, tmo: 1'b0});
    offer(1'b1, m1, 1'b1, m2);
    tick();
    offer(1'b0, 2'b00, 1'b0, 2'b00);
    check("rnd_strobe", round_strobe, 1'b1);
    tick();
    tick();
  endtask

  // Scoreboard drain: every strobe must match the oldest expected round.
  always @(negedge clk) begin
    if (reset === 1'b1 && round_strobe === 1'b1) begin
      check("sb_has_expect", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        round_t e;
        e = exp_q.pop_front();
        check("sb_g1", g1, e.g1);
        check("sb_g2", g2, e.g2);
        check("sb_tmo", timeout_flag, e.tmo);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    cfg_max    = 4'b0000;
    partita_in = 2'b00;
    offer(1'b0, 2'b00, 1'b0, 2'b00);
    tick();
    tick();
    check("rst_game_reset", game_reset, 1'b1);
    check("rst_g1", g1, 2'b00);
    check("rst_g2", g2, 2'b00);
    check("rst_p1_ready", mv_if.p1_ready, 1'b0);
    check("rst_p2_ready", mv_if.p2_ready, 1'b0);
    check("rst_round_cnt", round_cnt, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // Game 1: cfg 0110 -> config pattern g1=01, g2=10
    reset   = 1'b1;
    start   = 1'b1;
    cfg_max = 4'b0110;
    tick();
    start   = 1'b0;
    cfg_max = 4'b1111;
    check("cfg_game_reset", game_reset, 1'b1);
    check("cfg_g1", g1, 2'b01);
    check("cfg_g2", g2, 2'b10);
    check("cfg_busy", busy, 1'b1);
    tick();
    check("col_game_reset", game_reset, 1'b0);
    check("col_p1_ready", mv_if.p1_ready, 1'b1);
    check("col_g1", g1, 2'b00);

    // Round 1: players answer in different cycles
    exp_q.push_back('{g1: 2'b01, g2: 2'b10, tmo: 1'b0});
    offer(1'b1, 2'b01, 1'b0, 2'b00);
    tick();
    offer(1'b0, 2'b00, 1'b0, 2'b00);
    check("r1_p1_ready_full", mv_if.p1_ready, 1'b0);
    check("r1_p2_ready", mv_if.p2_ready, 1'b1);
    tick();
    tick();
    tick();
    check("r1_no_early_strobe", round_strobe, 1'b0);
    offer(1'b0, 2'b00, 1'b1, 2'b10);
    tick();
    offer(1'b0, 2'b00, 1'b0, 2'b00);
    check("r1_strobe", round_strobe, 1'b1);
    check("r1_cnt_in_issue", round_cnt, 5'd0);
    check("r1_ready_issue", mv_if.p1_ready, 1'b0);
    tick();
    check("r1_strobe_one_cycle", round_strobe, 1'b0);
    check("r1_cnt", round_cnt, 5'd1);
    check("r1_result_g1", g1, 2'b00);
    check("r1_result_ready", mv_if.p1_ready, 1'b0);
    tick();
    check("r1_ready_back", mv_if.p1_ready, 1'b1);

    // Round 2: simultaneous offers
    play_round(2'b11, 2'b11);

    // Round 3: p1 re-offers while full, p2 offers 00 first; game ends in RESULT
    exp_q.push_back('{g1: 2'b10, g2: 2'b11, tmo: 1'b0});
    offer(1'b1, 2'b10, 1'b1, 2'b00);
    tick();
    check("r3_p2_00_ignored", mv_if.p2_ready, 1'b1);
    offer(1'b1, 2'b01, 1'b1, 2'b00);
    tick();
    tick();
    offer(1'b1, 2'b01, 1'b1, 2'b11);
    tick();
    offer(1'b0, 2'b00, 1'b0, 2'b00);
    check("r3_strobe", round_strobe, 1'b1);
    partita_in = 2'b01;
    tick();
    tick();
    partita_in = 2'b00;
    check("end_done", done, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_game_reset", game_reset, 1'b0);
    offer(1'b1, 2'b01, 1'b1, 2'b01);
    tick();
    tick();
    offer(1'b0, 2'b00, 1'b0, 2'b00);
    check("end_done_held", done, 1'b1);
    check("end_p1_ready", mv_if.p1_ready, 1'b0);
    check("end_p2_ready", mv_if.p2_ready, 1'b0);
    check("end_round_cnt", round_cnt, 5'd3);

    // Game 2 from DONE with a new configuration
    start   = 1'b1;
    cfg_max = 4'b1001;
    tick();
    start   = 1'b0;
    check("g2_cfg_g1", g1, 2'b10);
    check("g2_cfg_g2", g2, 2'b01);
    check("g2_cfg_done", done, 1'b0);
    tick();
    check("g2_round_cnt", round_cnt, 5'd0);

    // Reset while p1's move is held: it must not reach the next game
    offer(1'b1, 2'b01, 1'b0, 2'b00);
    tick();
    offer(1'b0, 2'b00, 1'b0, 2'b00);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_game_reset", game_reset, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_p1_ready", mv_if.p1_ready, 1'b0);
    start   = 1'b1;
    cfg_max = 4'b0000;
    tick();
    start = 1'b0;
    tick();
    check("g3_p1_ready", mv_if.p1_ready, 1'b1);
    play_round(2'b11, 2'b01);

    // Abort mid-round: start beats p2's same-cycle offer and clears p1's move
    offer(1'b1, 2'b10, 1'b0, 2'b00);
    tick();
    start   = 1'b1;
    cfg_max = 4'b0011;
    offer(1'b0, 2'b00, 1'b1, 2'b10);
    tick();
    start = 1'b0;
    offer(1'b0, 2'b00, 1'b0, 2'b00);
    check("abort_cfg_g1", g1, 2'b00);
    check("abort_cfg_g2", g2, 2'b11);
    check("abort_no_strobe", round_strobe, 1'b0);
    tick();
    check("abort_p1_ready", mv_if.p1_ready, 1'b1);
    check("abort_p2_ready", mv_if.p2_ready, 1'b1);
    check("abort_round_cnt", round_cnt, 5'd0);

`ifdef MOVE_TIMEOUT_EN
    // Forfeit: p2 never answers, round issues 8 edges after p1's capture
    begin
      int n;
      exp_q.push_back('{g1: 2'b11, g2: 2'b00, tmo: 1'b1});
      offer(1'b1, 2'b11, 1'b0, 2'b00);
      tick();
      offer(1'b0, 2'b00, 1'b0, 2'b00);
      n = 0;
      while (round_strobe !== 1'b1 && n < 50) begin
        tick();
        n++;
      end
      check("tmo_latency", n, 8);
      check("tmo_flag", timeout_flag, 1'b1);
      tick();
      check("tmo_flag_pulse", timeout_flag, 1'b0);
      tick();
    end
`endif

    // Round counter saturates at all-ones
    for (int i = 0; i < 31; i++)
      play_round(2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)));
    check("sat_cnt_31", round_cnt, 5'd31);
    play_round(2'b01, 2'b11);
    check("sat_cnt_hold", round_cnt, 5'd31);
    check("sat_no_flag", timeout_flag, 1'b0);

    tick();
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
